// File: rtl/mem_access_ctrl.sv
// Memory access controller: owns MDDR and sequences loads/stores through SETUP/ACCESS/DONE.
// Optional build macro MACC_ACK_EN ends ACCESS on mem_ack (with timeout) instead of a fixed wait count.
module mem_access_ctrl #(
    parameter int ADDR_W      = 12,
    parameter int WAIT_CYCLES = 1,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [15:0]       A_bus,
    input  logic              clr,
    output logic              req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic              mem_ack,
    output logic [15:0]       MDDR,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [15:0]         mddr_q, mddr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                write_q, write_d;
    logic                re_q, re_d;
    logic                we_q, we_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                access_last_s;
    logic                timeout_s;
    logic [CNT_W-1:0]    cnt_load_s;
    logic [CNT_W-1:0]    cnt_step_s;
    logic                unused_s;

`ifdef MACC_ACK_EN
    // Counter holds the number of the current ACCESS cycle, starting at 1.
    assign timeout_s     = !mem_ack && (cnt_q == CNT_W'(ACK_TIMEOUT));
    assign access_last_s = mem_ack || timeout_s;
    assign cnt_load_s    = CNT_W'(1);
    assign cnt_step_s    = cnt_q + CNT_W'(1);
    assign unused_s      = (WAIT_CYCLES == 0);
`else
    assign timeout_s     = 1'b0;
    assign access_last_s = (cnt_q == CNT_W'(0));
    assign cnt_load_s    = CNT_W'(WAIT_CYCLES);
    assign cnt_step_s    = cnt_q - CNT_W'(1);
    assign unused_s      = mem_ack ^ (ACK_TIMEOUT == 0);
`endif

    assign req_ready = (state_q == ST_IDLE) && !clr && !reset;
    assign mem_addr  = addr_q;
    assign mem_wdata = mddr_q;
    assign mem_re    = re_q;
    assign mem_we    = we_q;
    assign MDDR      = mddr_q;
    assign done      = done_q;
    assign err       = err_q;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mddr_q  <= 16'h0000;
            addr_q  <= '0;
            write_q <= 1'b0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mddr_q  <= mddr_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            re_q    <= re_d;
            we_q    <= we_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!clr && req_valid) begin
                    state_d = ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (access_last_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ACCESS;
                end
            end
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, MDDR and the wait counter.
    always_comb begin
        cnt_d   = cnt_q;
        mddr_d  = mddr_q;
        addr_d  = addr_q;
        write_d = write_q;
        re_d    = re_q;
        we_d    = we_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // clr wins over a pending request.
                if (clr) begin
                    mddr_d = 16'h0000;
                end else if (req_valid) begin
                    addr_d  = req_addr;
                    write_d = req_write;
                    if (req_write) begin
                        mddr_d = A_bus;
                    end else begin
                        mddr_d = mddr_q;
                    end
                end else begin
                    mddr_d = mddr_q;
                end
            end
            ST_SETUP: begin
                cnt_d = cnt_load_s;
                re_d  = !write_q;
                we_d  = write_q;
            end
            ST_ACCESS: begin
                if (access_last_s) begin
                    re_d   = 1'b0;
                    we_d   = 1'b0;
                    done_d = 1'b1;
                    err_d  = timeout_s;
                    if (!write_q && !timeout_s) begin
                        mddr_d = mem_rdata;
                    end else begin
                        mddr_d = mddr_q;
                    end
                end else begin
                    cnt_d = cnt_step_s;
                end
            end
            ST_DONE: begin
                cnt_d = '0;
            end
            default: begin
                re_d = 1'b0;
                we_d = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences every data-memory transfer through the memory data register (MDDR) for the processor control unit.
- Owns the MDDR register. Latches the store operand from A_bus, drives the memory address and strobes with programmable wait states, and captures read data into MDDR.
- Sits between the control-unit state machine and the data memory.
- Replaces decoder-driven MDDR loads with a request/ready handshake.

Parameters:
- ADDR_W, 12: memory address width.
- WAIT_CYCLES, 1: extra strobe cycles per access (legal 0..15).
- ACK_TIMEOUT, 15: maximum ACCESS cycles awaiting mem_ack. Used only with MACC_ACK_EN.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  control unit requests an access.
- req_write  in  1  1 = store, 0 = load; sampled on accept.
- req_addr  in  ADDR_W  access address; sampled on accept.
- A_bus  in  16  store operand; sampled on accept when req_write=1.
- clr  in  1  clear MDDR to 0.
- req_ready  out  1  block is idle and can accept a request.
- mem_addr  out  ADDR_W  registered address to memory.
- mem_wdata  out  16  equals MDDR.
- mem_rdata  in  16  memory read data.
- mem_re  out  1  read strobe.
- mem_we  out  1  write strobe.
- mem_ack  in  1  memory acknowledge; ignored unless MACC_ACK_EN is defined.
- MDDR  out  16  memory data register.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle error flag, coincident with done.

Behaviour:
- Clock is "clock". Reset is synchronous and active-high, on port "reset"; it is sampled only on the rising edge of clock.
- Reset values: state=IDLE, MDDR=0, mem_addr=0, mem_re=0, mem_we=0, done=0, err=0, wait counter=0. req_ready is 0 during the reset cycle.
- Reset asserted mid-access aborts the access: strobes drop on the next edge and MDDR is cleared. No done pulse is produced.
- States are IDLE, SETUP, ACCESS, DONE.
- req_ready = (state==IDLE) && !clr && !reset. It is combinational from the registered state.
- IDLE:
  - If clr=1: MDDR<=0 and stay in IDLE. clr has priority over req_valid.
  - If req_valid && req_ready: accept. mem_addr<=req_addr, latch req_write, go to SETUP.
  - On a store accept, MDDR<=A_bus at the same edge.
  - clr outside IDLE is ignored.
- SETUP, exactly 1 cycle:
  - mem_addr is stable and both strobes are 0.
  - Load wait counter <= WAIT_CYCLES, go to ACCESS.
- ACCESS, WAIT_CYCLES+1 cycles:
  - mem_re=!write or mem_we=write, as registered outputs, high for every ACCESS cycle.
  - Counter decrements each cycle. The cycle with counter==0 is the last.
  - At the last-cycle edge: on a load, MDDR<=mem_rdata; strobes drop to 0; go to DONE.
- DONE, 1 cycle: done=1, err as described under Optional Feature. Return to IDLE.
- Latency from accept edge to done high: WAIT_CYCLES+2 cycles. req_ready returns WAIT_CYCLES+3 cycles after accept.
- Only one access is in flight; there is no queuing. req_valid held while not ready is not lost, and is accepted in IDLE.
- mem_addr holds its value after the access until the next accept.
- mem_we and mem_re are never both high.
- MDDR changes only on:
  - reset,
  - clr in IDLE,
  - store accept,
  - load last-ACCESS edge.

Optional Feature:
- Macro: MACC_ACK_EN.
- Defined:
  - ACCESS ends on the edge where mem_ack=1 is sampled, with a minimum of 1 ACCESS cycle. WAIT_CYCLES is ignored.
  - The counter counts ACCESS cycles. If ACK_TIMEOUT cycles elapse without mem_ack, strobes drop and the state goes to DONE with err=1. On a load, MDDR is left unchanged.
  - mem_ack is sampled only in ACCESS.
- Undefined:
  - Fixed-latency behaviour as described above.
  - mem_ack is unused and err is constant 0.

Test Plan:
- Reset then idle: hold reset 2 cycles -> MDDR=0x0000, strobes 0, done 0. req_ready=1 on the first cycle after reset is released.
- Store, WAIT_CYCLES=1: req_valid=1, req_write=1, req_addr=0x0A5, A_bus=0xBEEF -> MDDR=0xBEEF next edge, 1 SETUP cycle, mem_we=1 for 2 cycles with mem_addr=0x0A5 and mem_wdata=0xBEEF, done pulse at accept+3, req_ready at accept+4.
- Load: req_write=0, req_addr=0x010, memory returns 0x1234 -> mem_re=1 for 2 cycles, MDDR=0x1234 when done=1, mem_we stays 0.
- Clear priority: clr=1 together with req_valid=1 in IDLE, MDDR=0x00FF -> MDDR=0x0000, request not accepted. Accepted on the following cycle once clr=0.
- Reset mid-ACCESS of a load: assert reset in the first ACCESS cycle -> strobes 0 and MDDR=0 next edge, no done pulse, IDLE after release.
- With MACC_ACK_EN and ACK_TIMEOUT=15: mem_ack held 0 -> 15 ACCESS cycles, then done=1 and err=1 with MDDR unchanged. With mem_ack=1 in the 3rd ACCESS cycle -> done with err=0 and MDDR=mem_rdata.
